// File: rtl/poly_mult_tile_scheduler.sv
// poly_mult_tile_scheduler
//   Loads two operands of NUM_CHUNKS chunks each, N coefficients per chunk. It
//   sends every (i,j) chunk pair to an N x N polynomial multiplier array. Each
//   returned 2N-1 coefficient tile is overlap-added into a result accumulator.
//   The product is then streamed out chunk by chunk.
//   All coefficient arithmetic is mod 2^W.
//   Optional macro NEGACYCLIC_EN: reduce the product mod x^L + 1. With it, the
//   accumulator holds L coefficients and NUM_CHUNKS chunks are output.
//   Without it, the linear product is kept: 2L coefficients, 2*NUM_CHUNKS chunks.
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   load_valid/ready/sel/idx   operand chunk write (sel 0 = A, 1 = B), IDLE only
//   load_data                  N packed coefficients, index 0 = lowest power
//   op_start, busy             start pulse / operation in progress
//   mul_start, mul_as, mul_bs  tile issue to the multiplier (A chunk i, B chunk j)
//   mul_carry                  constant zero
//   mul_cs, mul_done           tile product and its strobe
//   out_valid/ready/data/last  result chunk stream
//
// state   | meaning
// IDLE    | accept operand loads, wait for op_start
// ISSUE   | one tile per cycle, i outer, j inner
// DRAIN   | wait for every outstanding tile to return
// OUTPUT  | stream accumulator chunks under valid/ready
module poly_mult_tile_scheduler #(
  parameter int MULTIPLIER_WIDTH = 8,
  parameter int INPUT_WIDTH      = 8,
  parameter int NUM_CHUNKS       = 4,
  parameter int MULT_LATENCY     = $clog2(MULTIPLIER_WIDTH)
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic                                          load_valid,
  output logic                                          load_ready,
  input  logic                                          load_sel,
  input  logic [$clog2(NUM_CHUNKS)-1:0]                 load_idx,
  input  logic [MULTIPLIER_WIDTH*INPUT_WIDTH-1:0]       load_data,
  input  logic                                          op_start,
  output logic                                          busy,
  output logic                                          mul_start,
  output logic [MULTIPLIER_WIDTH*INPUT_WIDTH-1:0]       mul_as,
  output logic [MULTIPLIER_WIDTH*INPUT_WIDTH-1:0]       mul_bs,
  output logic [(2*MULTIPLIER_WIDTH-1)*INPUT_WIDTH-1:0] mul_carry,
  input  logic [(2*MULTIPLIER_WIDTH-1)*INPUT_WIDTH-1:0] mul_cs,
  input  logic                                          mul_done,
  output logic                                          out_valid,
  input  logic                                          out_ready,
  output logic [MULTIPLIER_WIDTH*INPUT_WIDTH-1:0]       out_data,
  output logic                                          out_last
);

  localparam int N     = MULTIPLIER_WIDTH;
  localparam int W     = INPUT_WIDTH;
  localparam int NC    = NUM_CHUNKS;
  localparam int L     = NC * N;
  localparam int TW    = 2 * N - 1;
  localparam int CW    = $clog2(NC);
  localparam int TAG_W = $clog2(2 * NC);
  localparam int CNT_W = $clog2(NC * NC + 1);
`ifdef NEGACYCLIC_EN
  localparam int ACC_LEN    = L;
  localparam int OUT_CHUNKS = NC;
`else
  localparam int ACC_LEN    = 2 * L;
  localparam int OUT_CHUNKS = 2 * NC;
`endif
  localparam int AW = $clog2(ACC_LEN);
  localparam int OW = $clog2(OUT_CHUNKS);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_OUTPUT} state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      i_q, i_d, j_q, j_d;
  logic [OW-1:0]      out_idx_q, out_idx_d;
  logic [CNT_W-1:0]   outst_q, outst_d;
  logic               mul_start_q;
  logic [N*W-1:0]     mul_as_q, mul_bs_q;
  logic [N*W-1:0]     a_q [NC];
  logic [N*W-1:0]     b_q [NC];
  // Stage 0 travels with mul_start; stage MULT_LATENCY lines up with mul_done.
  logic [TAG_W-1:0]   tag_q [MULT_LATENCY+1];
  logic [W-1:0]       acc_q [ACC_LEN];
  logic [W-1:0]       acc_d [ACC_LEN];
  int                 acc_r;

  logic issue_en, start_op, last_tile, done_ok;

  assign last_tile = (i_q == CW'(NC - 1)) && (j_q == CW'(NC - 1));
  // A done with nothing outstanding is a protocol error (or a leftover after reset).
  assign done_ok   = mul_done && (outst_q != '0);

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (op_start) state_d = S_ISSUE;
      S_ISSUE:  if (last_tile) state_d = S_DRAIN;
      S_DRAIN:  if (outst_q == '0) state_d = S_OUTPUT;
      S_OUTPUT: if (out_ready && out_last) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy       = (state_q != S_IDLE);
    load_ready = (state_q == S_IDLE);
    start_op   = (state_q == S_IDLE) && op_start;
    issue_en   = (state_q == S_ISSUE);
    out_valid  = (state_q == S_OUTPUT);
    out_last   = out_valid && (out_idx_q == OW'(OUT_CHUNKS - 1));
    out_data   = '0;
    if (out_valid) begin
      for (int k = 0; k < N; k++)
        out_data[k*W +: W] = acc_q[AW'(int'(out_idx_q) * N + k)];
    end
  end

  always_comb begin
    i_d       = i_q;
    j_d       = j_q;
    out_idx_d = out_idx_q;
    if (issue_en) begin
      if (j_q == CW'(NC - 1)) begin
        j_d = '0;
        i_d = (i_q == CW'(NC - 1)) ? '0 : i_q + CW'(1);
      end else begin
        j_d = j_q + CW'(1);
      end
    end
    if (out_valid && out_ready)
      out_idx_d = out_last ? '0 : out_idx_q + OW'(1);
  end

  always_comb begin
    unique case ({issue_en, done_ok})
      2'b10:   outst_d = outst_q + CNT_W'(1);
      2'b01:   outst_d = outst_q - CNT_W'(1);
      default: outst_d = outst_q;
    endcase
  end

  // Overlap-add of the returning tile at offset tag*N.
  always_comb begin
    acc_r = 0;
    acc_d = acc_q;
    if (start_op) begin
      for (int a = 0; a < ACC_LEN; a++) acc_d[a] = '0;
    end else if (done_ok) begin
      for (int k = 0; k < TW; k++) begin
        acc_r = int'(tag_q[MULT_LATENCY]) * N + k;
`ifdef NEGACYCLIC_EN
        // x^L == -1: the upper half folds back onto the low half with a sign flip.
        if (acc_r >= L) acc_d[AW'(acc_r - L)] = acc_d[AW'(acc_r - L)] - mul_cs[k*W +: W];
        else            acc_d[AW'(acc_r)]     = acc_d[AW'(acc_r)] + mul_cs[k*W +: W];
`else
        acc_d[AW'(acc_r)] = acc_d[AW'(acc_r)] + mul_cs[k*W +: W];
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      i_q         <= '0;
      j_q         <= '0;
      out_idx_q   <= '0;
      outst_q     <= '0;
      mul_start_q <= 1'b0;
      mul_as_q    <= '0;
      mul_bs_q    <= '0;
      for (int s = 0; s <= MULT_LATENCY; s++) tag_q[s] <= '0;
      for (int c = 0; c < NC; c++) begin
        a_q[c] <= '0;
        b_q[c] <= '0;
      end
      for (int a = 0; a < ACC_LEN; a++) acc_q[a] <= '0;
    end else begin
      i_q         <= i_d;
      j_q         <= j_d;
      out_idx_q   <= out_idx_d;
      outst_q     <= outst_d;
      mul_start_q <= issue_en;
      if (issue_en) begin
        mul_as_q <= a_q[i_q];
        mul_bs_q <= b_q[j_q];
      end
      tag_q[0] <= issue_en ? TAG_W'(i_q) + TAG_W'(j_q) : '0;
      for (int s = 1; s <= MULT_LATENCY; s++) tag_q[s] <= tag_q[s-1];
      if (load_valid && load_ready) begin
        if (load_sel) b_q[load_idx] <= load_data;
        else          a_q[load_idx] <= load_data;
      end
      acc_q <= acc_d;
    end
  end

  assign mul_start = mul_start_q;
  assign mul_as    = mul_as_q;
  assign mul_bs    = mul_bs_q;
  assign mul_carry = '0;

endmodule
